mod12_down_counter: RTL and testbench

// - Synchronous modulo-N down counter. Default N=12, so it counts 11,10,...,0,11.
// - Counts in the reverse direction to the mod-12 up counter and is its companion block.
// - Used as a reload/timeout timer: loadable, gated by an enable, flags terminal count.
// - Keeps a saturating count of completed cycles for monitoring.

---
 rtl/mod12_down_counter_pkg.sv | 15 +
 rtl/mod12_down_counter_if.sv | 25 ++
 rtl/mod12_down_counter_sat_counter.sv | 20 ++
 rtl/mod12_down_counter.sv | 65 ++++++
 tb/tb_mod12_down_counter.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/mod12_down_counter_pkg.sv
// Shared defaults and helpers for the modulo-N down counter family.
// Holds the modulus/width defaults and the load clamp rule.
package mod12_down_counter_pkg;

  localparam int DEF_MOD    = 12;
  localparam int DEF_WIDTH  = 4;
  localparam int DEF_WRAP_W = 8;
  localparam int MAXV       = DEF_MOD - 1;

  // Out-of-range loads land on the top legal value so the count never leaves 0..modv-1.
  function automatic int clamp_load(input int val, input int modv = DEF_MOD);
    return (val >= modv) ? (modv - 1) : val;
  endfunction

endpackage

// File: rtl/mod12_down_counter_if.sv
// Control/status bundle for the modulo-N down counter.
// master drives enable/load, slave (the counter) returns count and flags.
interface mod12_down_counter_if #(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8
);
  logic              in_en;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic [WIDTH-1:0]  count_out;
  logic              tc;
  logic              is_zero;
  logic              load_err;
  logic [WRAP_W-1:0] wrap_cnt;

  modport master (
    output in_en, load, load_val,
    input  count_out, tc, is_zero, load_err, wrap_cnt
  );

  modport slave (
    input  in_en, load, load_val,
    output count_out, tc, is_zero, load_err, wrap_cnt
  );
endinterface

// File: rtl/mod12_down_counter_sat_counter.sv
// Saturating event counter: increments once per clock while inc is high, sticks at all-ones.
// Registered output, one clock from inc to q; no backpressure.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (inc && !(&q)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/mod12_down_counter.sv
// Loadable modulo-MOD down counter with terminal-count pulse, load-error pulse and wrap monitor.
// All flags registered on the sampling edge (zero extra latency); is_zero is combinational.
import mod12_down_counter_pkg::*;

module mod12_down_counter #(
  parameter int MOD    = DEF_MOD,
  parameter int WIDTH  = DEF_WIDTH,
  parameter int WRAP_W = DEF_WRAP_W
) (
  input logic                 clk,
  input logic                 rst_n,
  mod12_down_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] L_MAXV = WIDTH'(MOD - 1);

  logic [WIDTH-1:0]  r_count;
  logic              r_tc;
  logic              r_load_err;
  logic              w_wrap;
  logic              w_load_bad;
  logic [WIDTH-1:0]  w_load_clamped;
  logic [WRAP_W-1:0] w_wrap_cnt;

  assign w_load_bad     = int'(bus.load_val) >= MOD;
  assign w_load_clamped = WIDTH'(clamp_load(int'(bus.load_val), MOD));
  // Wrap is keyed on the current value being zero, not on a decrement borrow.
  assign w_wrap         = !bus.load && bus.in_en && (r_count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count    <= '0;
      r_tc       <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_tc       <= 1'b0;
      r_load_err <= 1'b0;
      if (bus.load) begin
        r_count    <= w_load_clamped;
        r_load_err <= w_load_bad;
      end else if (bus.in_en) begin
        if (r_count == '0) begin
          r_count <= L_MAXV;
          r_tc    <= 1'b1;
        end else begin
          r_count <= r_count - WIDTH'(1);
        end
      end
    end
  end

  sat_counter #(.W(WRAP_W)) u_wrap_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_wrap),
    .q     (w_wrap_cnt)
  );

  assign bus.count_out = r_count;
  assign bus.tc        = r_tc;
  assign bus.load_err  = r_load_err;
  assign bus.is_zero   = (r_count == '0);
  assign bus.wrap_cnt  = w_wrap_cnt;

endmodule

// File: tb/tb_mod12_down_counter.sv
// Directed bench for mod12_down_counter: main instance (WRAP_W=8) plus a WRAP_W=2 instance for saturation.
module tb_mod12_down_counter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  mod12_down_counter_if #(.WIDTH(4), .WRAP_W(8)) bus  ();
  mod12_down_counter_if #(.WIDTH(4), .WRAP_W(2)) bus2 ();

  mod12_down_counter #(.MOD(12), .WIDTH(4), .WRAP_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  mod12_down_counter #(.MOD(12), .WIDTH(4), .WRAP_W(2)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n         = 1'b0;
    bus.in_en     = 1'b0;
    bus.load      = 1'b0;
    bus.load_val  = '0;
    bus2.in_en    = 1'b0;
    bus2.load     = 1'b0;
    bus2.load_val = '0;

    #22;
    chk("rst_count", bus.count_out, 0);
    chk("rst_tc", bus.tc, 0);
    chk("rst_load_err", bus.load_err, 0);
    chk("rst_wrap_cnt", bus.wrap_cnt, 0);
    chk("rst_is_zero", bus.is_zero, 1);
    rst_n = 1'b1;
    tick();
    chk("idle_count", bus.count_out, 0);

    // Free run: 13 clocks from 0 -> 11..0, 11 with tc on clocks 1 and 13
    bus.in_en = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      tick();
      chk($sformatf("free_count_%0d", k), bus.count_out, 11 - ((k - 1) % 12));
      chk($sformatf("free_tc_%0d", k), bus.tc, (k == 1 || k == 13) ? 1 : 0);
    end
    chk("free_wrap_cnt", bus.wrap_cnt, 2);

    // Load 5 with in_en also high: load wins
    bus.load     = 1'b1;
    bus.load_val = 4'd5;
    tick();
    chk("load5_count", bus.count_out, 5);
    chk("load5_tc", bus.tc, 0);
    chk("load5_err", bus.load_err, 0);
    bus.load = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("dec_count_%0d", k), bus.count_out, 5 - k);
      chk($sformatf("dec_tc_%0d", k), bus.tc, 0);
    end
    chk("dec_is_zero", bus.is_zero, 1);
    chk("wrap_kept_after_load", bus.wrap_cnt, 2);

    // Load at count 0 with in_en high must not wrap
    bus.load     = 1'b1;
    bus.load_val = 4'd0;
    tick();
    chk("load0_count", bus.count_out, 0);
    chk("load0_tc", bus.tc, 0);
    chk("load0_wrap_cnt", bus.wrap_cnt, 2);

    // Illegal load clamps to 11, load_err for exactly one cycle
    bus.load_val = 4'd14;
    tick();
    chk("bad_load_count", bus.count_out, 11);
    chk("bad_load_err", bus.load_err, 1);
    chk("bad_load_tc", bus.tc, 0);
    bus.load  = 1'b0;
    bus.in_en = 1'b0;
    tick();
    chk("bad_load_err_clear", bus.load_err, 0);
    chk("bad_load_hold", bus.count_out, 11);

    // Boundary legal load value 11
    bus.load     = 1'b1;
    bus.load_val = 4'd11;
    tick();
    chk("load11_count", bus.count_out, 11);
    chk("load11_err", bus.load_err, 0);

    // Hold at 3 for 10 clocks
    bus.load_val = 4'd3;
    tick();
    bus.load = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("hold_count_%0d", k), bus.count_out, 3);
      chk($sformatf("hold_tc_%0d", k), bus.tc, 0);
    end
    chk("hold_is_zero", bus.is_zero, 0);

    // Async reset mid-count at 7: clears without a clock edge
    bus.load     = 1'b1;
    bus.load_val = 4'd7;
    tick();
    bus.load  = 1'b0;
    bus.in_en = 1'b1;
    chk("pre_rst_count", bus.count_out, 7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_count", bus.count_out, 0);
    chk("async_rst_wrap_cnt", bus.wrap_cnt, 0);
    chk("async_rst_tc", bus.tc, 0);
    chk("async_rst_load_err", bus.load_err, 0);
    bus.in_en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Saturation with WRAP_W=2: wraps on clocks 1, 13, 25, 37, 49
    bus2.in_en = 1'b1;
    for (int k = 1; k <= 55; k++) begin
      int wraps;
      tick();
      wraps = (k - 1) / 12 + 1;
      if (k == 1 || k == 13 || k == 25 || k == 37 || k == 49 || k == 55)
        chk($sformatf("sat_wrap_cnt_%0d", k), bus2.wrap_cnt, (wraps > 3) ? 3 : wraps);
    end
    chk("sat_count", bus2.count_out, 5);
    chk("main_idle_during_sat", bus.count_out, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
